// File: rtl/stack_machine_pkg.sv
// Shared stack-machine types: opcodes, fetch states and decode helpers.
package stack_machine_pkg;

  typedef enum logic [7:0] {
    OP_ADD = 8'd0,
    OP_SUB = 8'd1,
    OP_AND = 8'd2,
    OP_ORR = 8'd3,
    OP_XOR = 8'd4,
    OP_NOT = 8'd5,
    OP_DUP = 8'd6,
    OP_DRP = 8'd7,
    OP_PSI = 8'd8,
    OP_PSH = 8'd9,
    OP_STR = 8'd10,
    OP_SWP = 8'd11,
    OP_JPZ = 8'd12,
    OP_JPN = 8'd13,
    OP_FIN = 8'd14,
    OP_NUL = 8'd15,
    OP_CAL = 8'd16,
    OP_RET = 8'd17,
    OP_CAR = 8'd18
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_IMM,
    HOLD,
    HALT
  } fetch_state_t;

  localparam logic [7:0] OP_MAX = 8'd18;

  function automatic logic has_imm(opcode_t op);
    return op inside {OP_PSI, OP_PSH, OP_STR,
                      OP_JPZ, OP_JPN, OP_CAL, OP_CAR};
  endfunction

  function automatic logic is_legal(logic [7:0] b);
    return b <= OP_MAX;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus bundle: program memory port, instruction handshake to
// execute, and the redirect path back from execute.
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_busy;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_op;
  logic [DATA_W-1:0] instr_imm;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;

  modport master (
    output mem_addr, instr_valid, instr_op,
    output instr_imm, instr_pc, halted,
    input  mem_data, mem_busy, instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_addr, instr_valid, instr_op,
    input  instr_imm, instr_pc, halted,
    output mem_data, mem_busy, instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Stack-machine instruction fetch: PC walker, opcode/immediate latch,
// valid/ready to execute. FETCH_ILLEGAL_TRAP_EN halts on opcodes > 18.
module instr_fetch
  import stack_machine_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clock,
  input logic         reset,
  instr_fetch_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              fetching;
  logic              xfer;
  logic              trap;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign trap = !is_legal(bus.mem_data);
`else
  assign trap = 1'b0;
`endif

  assign fetching = (state_q == FETCH_OP) ||
                    (state_q == FETCH_IMM);
  assign xfer = (state_q == HOLD) && bus.instr_ready;

  assign bus.mem_addr    = fetching ? pc_q : addr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.halted      = (state_q == HALT);
  assign bus.instr_op    = op_q;
  assign bus.instr_imm   = imm_q;
  assign bus.instr_pc    = ipc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    op_d    = op_q;
    imm_d   = imm_q;
    unique case (state_q)
      FETCH_OP: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end else if (!bus.mem_busy) begin
          ipc_d = pc_q;
          pc_d  = pc_q + 1'b1;
          if (trap) begin
            state_d = HALT;
          end else begin
            op_d = bus.mem_data;
            if (has_imm(opcode_t'(bus.mem_data))) begin
              state_d = FETCH_IMM;
            end else begin
              imm_d   = '0;
              state_d = HOLD;
            end
          end
        end
      end
      FETCH_IMM: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH_OP;
        end else if (!bus.mem_busy) begin
          imm_d   = bus.mem_data;
          pc_d    = pc_q + 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // An accepted FIN beats a simultaneous redirect.
        if (xfer && op_q == DATA_W'(OP_FIN)) begin
          state_d = HALT;
        end else if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH_OP;
        end else if (xfer) begin
          state_d = FETCH_OP;
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_OP;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ipc_q   <= '0;
      op_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= bus.mem_addr;
      ipc_q   <= ipc_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model, instruction scoreboard, vector table
// plus hand sequences for stall, busy, redirect, wrap, illegal, reset.
module tb_instr_fetch;
  import stack_machine_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instr_fetch_if bus ();
  logic [7:0] mem [256];

  assign bus.mem_data = mem[bus.mem_addr];

  instr_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] op;
    logic [7:0] imm;
    bit         two;
  } vec_t;

  exp_t sbq[$];
  int   total = 0;
  int   passed = 0;

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  function automatic void push(logic [7:0] op,
                               logic [7:0] imm,
                               logic [7:0] pc);
    exp_t e;
    e.op = op;
    e.imm = imm;
    e.pc = pc;
    sbq.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_instr: op=%0d pc=%0h",
                 bus.instr_op, bus.instr_pc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_op", 32'(bus.instr_op), 32'(e.op));
        check("sb_imm", 32'(bus.instr_imm), 32'(e.imm));
        check("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd14;
    sbq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_busy = 1'b0;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_until_halt(input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clock);
      #1 n++;
      if (bus.halted) break;
    end
    if (!bus.halted) begin
      total++;
      $display("FAIL halt_timeout: halted=0 after %0d cycles", n);
    end
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clock);
      #1;
      if (bus.instr_valid) break;
    end
    check("wait_valid", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic sb_drained(string name);
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  vec_t vt[6];
  int   n;

  initial begin
    vt[0] = '{8'h00, 8'd8,  8'd10,   1'b1};
    vt[1] = '{8'h02, 8'd0,  8'd0,    1'b0};
    vt[2] = '{8'h03, 8'd12, 8'd5,    1'b1};
    vt[3] = '{8'h05, 8'd6,  8'd0,    1'b0};
    vt[4] = '{8'h06, 8'd16, 8'h33,   1'b1};
    vt[5] = '{8'h08, 8'd14, 8'd0,    1'b0};

    // Reset state
    clear_mem();
    reset = 1'b1;
    bus.mem_busy = 1'b0;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    #12;
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_op", 32'(bus.instr_op), 32'd0);
    check("rst_imm", 32'(bus.instr_imm), 32'd0);
    check("rst_pc", 32'(bus.instr_pc), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);

    // Table program, full throughput
    foreach (vt[i]) begin
      mem[vt[i].addr] = vt[i].op;
      if (vt[i].two) mem[vt[i].addr + 8'd1] = vt[i].imm;
      push(vt[i].op, vt[i].two ? vt[i].imm : 8'd0, vt[i].addr);
    end
    do_reset();
    run_until_halt(40, n);
    check("t1_cycles", 32'(n), 32'd15);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("t1_halted", 32'(bus.halted), 32'd1);
      check("t1_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.redirect_valid = 1'b0;
    sb_drained("t1_drained");

    // Back-pressure with PSI held
    clear_mem();
    mem[0] = 8'd8;
    mem[1] = 8'd20;
    push(8'd8, 8'd20, 8'd0);
    push(8'd14, 8'd0, 8'd2);
    do_reset();
    bus.instr_ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("t2_valid", 32'(bus.instr_valid), 32'd1);
      check("t2_op", 32'(bus.instr_op), 32'd8);
      check("t2_imm", 32'(bus.instr_imm), 32'd20);
      check("t2_pc", 32'(bus.instr_pc), 32'd0);
      check("t2_addr", 32'(bus.mem_addr), 32'd1);
    end
    bus.instr_ready = 1'b1;
    run_until_halt(20, n);
    sb_drained("t2_drained");

    // mem_busy during immediate fetch
    clear_mem();
    mem[0] = 8'd13;
    mem[1] = 8'd21;
    push(8'd13, 8'd21, 8'd0);
    push(8'd14, 8'd0, 8'd2);
    do_reset();
    @(posedge clock);
    #1 bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("t3_valid", 32'(bus.instr_valid), 32'd0);
      check("t3_addr", 32'(bus.mem_addr), 32'd1);
    end
    bus.mem_busy = 1'b0;
    run_until_halt(20, n);
    check("t3_cycles", 32'(n), 32'd4);
    sb_drained("t3_drained");

    // Redirect during immediate fetch
    clear_mem();
    mem[0] = 8'd8;
    mem[1] = 8'd7;
    mem[21] = 8'd6;
    push(8'd6, 8'd0, 8'd21);
    push(8'd14, 8'd0, 8'd22);
    do_reset();
    @(posedge clock);
    #1 bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'd21;
    @(posedge clock);
    #1 bus.redirect_valid = 1'b0;
    run_until_halt(20, n);
    sb_drained("t4_drained");

    // Handshake + redirect same cycle, then FIN beats redirect
    clear_mem();
    mem[0] = 8'd0;
    mem[8'h30] = 8'd14;
    push(8'd0, 8'd0, 8'd0);
    push(8'd14, 8'd0, 8'h30);
    do_reset();
    wait_valid(5);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h30;
    @(posedge clock);
    #1 bus.redirect_valid = 1'b0;
    wait_valid(5);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h00;
    @(posedge clock);
    #1 bus.redirect_valid = 1'b0;
    check("t7_halt", 32'(bus.halted), 32'd1);
    sb_drained("t7_drained");

    // PC wrap: one-byte at FF, then PSI at FF
    clear_mem();
    mem[8'hFF] = 8'd6;
    push(8'd6, 8'd0, 8'hFF);
    push(8'd14, 8'd0, 8'h00);
    reset = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'hFF;
    @(posedge clock);
    #1 bus.redirect_valid = 1'b0;
    run_until_halt(20, n);
    sb_drained("t5a_drained");

    clear_mem();
    mem[8'hFF] = 8'd8;
    mem[8'h00] = 8'h55;
    push(8'd8, 8'h55, 8'hFF);
    push(8'd14, 8'd0, 8'h01);
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'hFF;
    @(posedge clock);
    #1 bus.redirect_valid = 1'b0;
    run_until_halt(20, n);
    sb_drained("t5b_drained");

    // Illegal opcode
    clear_mem();
    mem[0] = 8'd40;
`ifdef FETCH_ILLEGAL_TRAP_EN
    do_reset();
    @(posedge clock);
    #1;
    check("t6_halted", 32'(bus.halted), 32'd1);
    check("t6_pc", 32'(bus.instr_pc), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 check("t6_valid", 32'(bus.instr_valid), 32'd0);
    end
`else
    push(8'd40, 8'd0, 8'd0);
    push(8'd14, 8'd0, 8'd1);
    do_reset();
    run_until_halt(20, n);
    check("t6_cycles", 32'(n), 32'd4);
`endif
    sb_drained("t6_drained");

    // Async reset in HOLD
    clear_mem();
    mem[0] = 8'd8;
    mem[1] = 8'h99;
    do_reset();
    bus.instr_ready = 1'b0;
    wait_valid(10);
    check("t8_op_pre", 32'(bus.instr_op), 32'd8);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t8_valid", 32'(bus.instr_valid), 32'd0);
    check("t8_op", 32'(bus.instr_op), 32'd0);
    check("t8_imm", 32'(bus.instr_imm), 32'd0);
    check("t8_pc", 32'(bus.instr_pc), 32'd0);
    check("t8_addr", 32'(bus.mem_addr), 32'd0);
    check("t8_halted", 32'(bus.halted), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
